// File: rtl/general_register_file.sv
// general_register_file: eight WIDTH-bit registers (R1-R4 general purpose,
// S1-S4 scratch) with two combinational read ports feeding the ALU operands
// and one write port that applies a shared register function to every
// enabled register on the rising clock edge.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   - a read port that selects a register being loaded (FunSel 010)
//               this cycle shows I combinationally in the same cycle.
//   undefined - read ports always show stored contents (one-cycle latency).
//
// Register index map (shared by the read selects and the enable vector):
//   0..3 = R1..R4 (RegSel bit 0..3), 4..7 = S1..S4 (ScrSel bit 0..3).
// Byte-oriented functions assume WIDTH = 16.

module general_register_file #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam logic [2:0] FUN_DEC      = 3'b000;
  localparam logic [2:0] FUN_INC      = 3'b001;
  localparam logic [2:0] FUN_LOAD     = 3'b010;
  localparam logic [2:0] FUN_CLEAR    = 3'b011;
  localparam logic [2:0] FUN_CLR_LO   = 3'b100;
  localparam logic [2:0] FUN_LOAD_LO  = 3'b101;
  localparam logic [2:0] FUN_LOAD_HI  = 3'b110;
  localparam logic [2:0] FUN_SEXT_LO  = 3'b111;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  // Next value of one register under the given function; arithmetic wraps
  // modulo 2^WIDTH and no flags are produced.
  function automatic logic [WIDTH-1:0] apply_fun(
    input logic [2:0]       fun,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (fun)
      FUN_DEC:     r = q - ONE;
      FUN_INC:     r = q + ONE;
      FUN_LOAD:    r = din;
      FUN_CLEAR:   r = ZERO;
      FUN_CLR_LO:  r = {{(WIDTH-8){1'b0}}, din[7:0]};
      FUN_LOAD_LO: r[7:0] = din[7:0];
      FUN_LOAD_HI: r[15:8] = din[7:0];
      FUN_SEXT_LO: r = {{(WIDTH-8){din[7]}}, din[7:0]};
      default:     r = q;
    endcase
    return r;
  endfunction

  logic [7:0]            en_s;
  logic [7:0][WIDTH-1:0] regs_d;
  logic [7:0][WIDTH-1:0] regs_q;

  assign en_s = {ScrSel, RegSel};

  // Compute each register's next value: enabled registers take the function
  // of their own current value, disabled ones hold.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 8; i++) begin
      if (en_s[i]) begin
        regs_d[i] = apply_fun(FunSel, regs_q[i], I);
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage; Reset clears everything immediately and dominates
  // for as long as it is held.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef RF_BYPASS_EN
  logic bypass_a_s;
  logic bypass_b_s;

  // A port bypasses only a plain load into the register it is reading;
  // Reset suppresses the bypass so the ports read zero while it is held.
  always_comb begin
    bypass_a_s = 1'b0;
    bypass_b_s = 1'b0;
    if (!Reset && (FunSel == FUN_LOAD)) begin
      bypass_a_s = en_s[OutASel];
      bypass_b_s = en_s[OutBSel];
    end else begin
      bypass_a_s = 1'b0;
      bypass_b_s = 1'b0;
    end
  end

  // Operand read ports with same-cycle load forwarding.
  always_comb begin
    OutA = regs_q[OutASel];
    OutB = regs_q[OutBSel];
    if (bypass_a_s) begin
      OutA = I;
    end else begin
      OutA = regs_q[OutASel];
    end
    if (bypass_b_s) begin
      OutB = I;
    end else begin
      OutB = regs_q[OutBSel];
    end
  end
`else
  // Operand read ports: plain combinational reads of stored contents.
  always_comb begin
    OutA = regs_q[OutASel];
    OutB = regs_q[OutBSel];
  end
`endif

endmodule

// File: tb/tb_general_register_file.sv
// Directed, table-driven bench for general_register_file. Each table record
// performs one write at a clock edge, then reads two registers with all
// enables cleared and compares against hand-computed values. Multi-cycle
// corner cases (concurrent multi-enable reads, bypass, async reset) follow
// as hand-written sequences.

module tb_general_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [15:0] OutA;
  logic [15:0] OutB;

  int n_vec = 0;
  int n_err = 0;

  general_register_file #(.WIDTH(16)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [2:0]  fun;
    logic [3:0]  rsel;
    logic [3:0]  ssel;
    logic [15:0] din;
    logic [2:0]  asel;
    logic [2:0]  bsel;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic [2:0] fun,
                              input logic [3:0] rsel, input logic [3:0] ssel,
                              input logic [15:0] din, input logic [2:0] asel,
                              input logic [2:0] bsel, input logic [15:0] exp_a,
                              input logic [15:0] exp_b);
    vec_t v;
    v.name = name; v.fun = fun; v.rsel = rsel; v.ssel = ssel; v.din = din;
    v.asel = asel; v.bsel = bsel; v.exp_a = exp_a; v.exp_b = exp_b;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset   = 1'b1;
    I       = 16'h0000;
    FunSel  = 3'b000;
    RegSel  = 4'b0000;
    ScrSel  = 4'b0000;
    OutASel = 3'd0;
    OutBSel = 3'd0;

    // Table: write at one edge, then read back with enables cleared.
    vq.push_back(mk("ld_r1",     3'b010, 4'b0001, 4'b0000, 16'h1234, 3'd0, 3'd1, 16'h1234, 16'h0000));
    vq.push_back(mk("ld_s1",     3'b010, 4'b0000, 4'b0001, 16'hFFFF, 3'd4, 3'd0, 16'hFFFF, 16'h1234));
    vq.push_back(mk("inc_wrap",  3'b001, 4'b0000, 4'b0001, 16'h0000, 3'd4, 3'd5, 16'h0000, 16'h0000));
    vq.push_back(mk("dec_wrap",  3'b000, 4'b0000, 4'b0001, 16'h0000, 3'd4, 3'd4, 16'hFFFF, 16'hFFFF));
    vq.push_back(mk("ld_r2",     3'b010, 4'b0010, 4'b0000, 16'hABCD, 3'd1, 3'd0, 16'hABCD, 16'h1234));
    vq.push_back(mk("lo_byte",   3'b101, 4'b0010, 4'b0000, 16'h0080, 3'd1, 3'd4, 16'hAB80, 16'hFFFF));
    vq.push_back(mk("ld_r2_b",   3'b010, 4'b0010, 4'b0000, 16'hABCD, 3'd1, 3'd2, 16'hABCD, 16'h0000));
    vq.push_back(mk("hi_byte",   3'b110, 4'b0010, 4'b0000, 16'h0080, 3'd1, 3'd1, 16'h80CD, 16'h80CD));
    vq.push_back(mk("sext",      3'b111, 4'b0010, 4'b0000, 16'h0080, 3'd1, 3'd0, 16'hFF80, 16'h1234));
    vq.push_back(mk("clr_ld_lo", 3'b100, 4'b0010, 4'b0000, 16'h0080, 3'd1, 3'd4, 16'h0080, 16'hFFFF));
    vq.push_back(mk("no_enable", 3'b011, 4'b0000, 4'b0000, 16'h5555, 3'd0, 3'd4, 16'h1234, 16'hFFFF));
    vq.push_back(mk("clr_s1",    3'b011, 4'b0000, 4'b0001, 16'h5555, 3'd4, 3'd0, 16'h0000, 16'h1234));
    vq.push_back(mk("ld_r1_5",   3'b010, 4'b0001, 4'b0000, 16'h0005, 3'd0, 3'd0, 16'h0005, 16'h0005));
    vq.push_back(mk("ld_s2_9",   3'b010, 4'b0000, 4'b0010, 16'h0009, 3'd5, 3'd4, 16'h0009, 16'h0000));
    vq.push_back(mk("inc_r1_s2", 3'b001, 4'b0001, 4'b0010, 16'h0000, 3'd0, 3'd5, 16'h0006, 16'h000A));
    vq.push_back(mk("dec_r2_s2", 3'b000, 4'b0010, 4'b0010, 16'h0000, 3'd1, 3'd5, 16'h007F, 16'h0009));
    vq.push_back(mk("ld_r1_r4",  3'b010, 4'b1001, 4'b0000, 16'h0003, 3'd0, 3'd3, 16'h0003, 16'h0003));
    vq.push_back(mk("ld_r4_7",   3'b010, 4'b1000, 4'b0000, 16'h0007, 3'd3, 3'd0, 16'h0007, 16'h0003));
    vq.push_back(mk("sext_s3s4", 3'b111, 4'b0000, 4'b1100, 16'h127F, 3'd6, 3'd7, 16'h007F, 16'h007F));

    // Reset state: every select reads zero.
    #1;
    for (int s = 0; s < 8; s++) begin
      OutASel = 3'(s);
      OutBSel = 3'(7 - s);
      #1;
      check("reset_a", OutA, 16'h0000);
      check("reset_b", OutB, 16'h0000);
    end
    tick();
    Reset = 1'b0;

    // Table-driven write/readback.
    foreach (vq[k]) begin
      FunSel = vq[k].fun;
      RegSel = vq[k].rsel;
      ScrSel = vq[k].ssel;
      I      = vq[k].din;
      tick();
      RegSel  = 4'b0000;
      ScrSel  = 4'b0000;
      OutASel = vq[k].asel;
      OutBSel = vq[k].bsel;
      #1;
      check({vq[k].name, "_a"}, OutA, vq[k].exp_a);
      check({vq[k].name, "_b"}, OutB, vq[k].exp_b);
    end

    // Multi-enable increment with concurrent reads of both targets.
    OutASel = 3'd0;
    OutBSel = 3'd3;
    FunSel  = 3'b001;
    RegSel  = 4'b1001;
    #1;
    check("multi_pre_a", OutA, 16'h0003);
    check("multi_pre_b", OutB, 16'h0007);
    tick();
    RegSel = 4'b0000;
    #1;
    check("multi_post_a", OutA, 16'h0004);
    check("multi_post_b", OutB, 16'h0008);

    // Load into R3 while port B watches it.
    OutBSel = 3'd2;
    FunSel  = 3'b010;
    RegSel  = 4'b0100;
    I       = 16'h5A5A;
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_same_cycle", OutB, 16'h5A5A);
`else
    check("no_bypass_old", OutB, 16'h0000);
`endif
    check("bypass_other_port", OutA, 16'h0004);
    tick();
    RegSel = 4'b0000;
    #1;
    check("bypass_after_edge", OutB, 16'h5A5A);

    // Increment is never forwarded: old value until the edge.
    FunSel = 3'b001;
    RegSel = 4'b0100;
    #1;
    check("inc_not_bypassed", OutB, 16'h5A5A);
    tick();
    RegSel = 4'b0000;
    #1;
    check("inc_r3", OutB, 16'h5A5B);

    // Asynchronous reset mid-cycle with every enable set.
    FunSel = 3'b010;
    RegSel = 4'b1111;
    ScrSel = 4'b1111;
    I      = 16'hBEEF;
    #1;
    Reset = 1'b1;
    #1;
    for (int s = 0; s < 8; s++) begin
      OutASel = 3'(s);
      OutBSel = 3'(7 - s);
      #1;
      check("async_reset_a", OutA, 16'h0000);
      check("async_reset_b", OutB, 16'h0000);
    end
    tick();
    check("reset_held_a", OutA, 16'h0000);
    Reset = 1'b0;
    OutASel = 3'd6;
    FunSel  = 3'b001;
    #1;
    check("post_reset_pre_edge", OutA, 16'h0000);
    tick();
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
    #1;
    check("first_write_after_reset", OutA, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
